// File: rtl/audio_dma_pkg.sv
// rtl/audio_dma_pkg.sv - shared state type and requester constants for the audio DMA arbiter
package audio_dma_pkg;

    localparam int AUDIO_DMA_NUM_REQ = 4;

    localparam int REQ_I2S   = 0;
    localparam int REQ_TDM   = 1;
    localparam int REQ_PDM   = 2;
    localparam int REQ_SPDIF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/audio_rr_picker.sv
// rtl/audio_rr_picker.sv - rotate-priority encoder: first set request at or after rr_ptr, wrapping
module audio_rr_picker
    import audio_dma_pkg::*;
#(
    parameter int NUM_REQ = AUDIO_DMA_NUM_REQ,
    parameter int CH_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [CH_W-1:0]    rr_ptr,
    output logic [CH_W-1:0]    winner,
    output logic               valid
);

    localparam int SW = CH_W + 1;

    logic [SW-1:0]   sum;
    logic [CH_W-1:0] idx;

    // Walk from the farthest offset down so the closest requester to rr_ptr is assigned last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            idx = sum[CH_W-1:0];
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_dma_arbiter.sv
// rtl/audio_dma_arbiter.sv - round-robin owner of the audio DMA channel; AUDIO_DMA_WDOG_EN adds the idle-beat watchdog
module audio_dma_arbiter
    import audio_dma_pkg::*;
#(
    parameter int NUM_REQ = AUDIO_DMA_NUM_REQ,
    parameter int CH_W    = 2,
    parameter int BL_W    = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic               pclk,
    input  logic               prst,
    input  logic               arb_enable,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [BL_W-1:0]    cfg_burst_len,
    output logic               dma_req_o,
    output logic [CH_W-1:0]    dma_ch_o,
    output logic [BL_W-1:0]    dma_len_o,
    input  logic               dma_ack_i,
    input  logic               dma_beat_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               abort_o
);

    if (TIMEOUT < 2 || (1 << CH_W) < NUM_REQ) begin : g_bad_params
        $error("audio_dma_arbiter: TIMEOUT must be >= 2 and CH_W must index NUM_REQ");
    end

    arb_state_e      state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q, winner_q, pick_winner;
    logic [BL_W-1:0] len_q, beat_cnt_q;
    logic            pick_valid, last_beat, wdog_expired;
    logic            done_q, done_d, abort_q, abort_d;

    audio_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .CH_W    (CH_W)
    ) u_picker (
        .req    (req_i),
        .rr_ptr (rr_ptr_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign last_beat = dma_beat_i && ((beat_cnt_q + BL_W'(1)) == len_q);

`ifdef AUDIO_DMA_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT);
    logic [WD_W-1:0] idle_cnt_q;

    always_ff @(posedge pclk) begin
        if (prst || state_q != XFER || dma_beat_i) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + WD_W'(1);
        end
    end

    assign wdog_expired = (idle_cnt_q == WD_W'(TIMEOUT - 1));
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_enable && pick_valid) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (dma_ack_i) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (last_beat) begin
                    state_d = RELEASE;
                    done_d  = 1'b1;
                end else if (!dma_beat_i && wdog_expired) begin
                    state_d = RELEASE;
                    abort_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Winner and length are frozen at grant time so later request or config changes only affect the next burst.
    always_ff @(posedge pclk) begin
        if (prst) begin
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= done_d;
            abort_q <= abort_d;
            if (state_q == IDLE && state_d == CMD) begin
                winner_q <= pick_winner;
                len_q    <= (cfg_burst_len == '0) ? BL_W'(1) : cfg_burst_len;
            end
            if (state_q == CMD) begin
                beat_cnt_q <= '0;
            end else if (state_q == XFER && dma_beat_i) begin
                beat_cnt_q <= beat_cnt_q + BL_W'(1);
            end
            if (state_q == RELEASE) begin
                rr_ptr_q <= (winner_q == CH_W'(NUM_REQ - 1)) ? '0 : winner_q + CH_W'(1);
            end
        end
    end

    assign dma_req_o = (state_q == CMD);
    assign dma_ch_o  = dma_req_o ? winner_q : '0;
    assign dma_len_o = dma_req_o ? len_q : '0;
    assign gnt_o     = (state_q == CMD || state_q == XFER) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q) : '0;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign abort_o   = abort_q;

endmodule

// File: tb/tb_audio_dma_arbiter.sv
// tb/tb_audio_dma_arbiter.sv - scoreboard bench for audio_dma_arbiter with a round-robin reference model
module tb_audio_dma_arbiter;
    import audio_dma_pkg::*;

    logic       pclk = 1'b0;
    logic       prst = 1'b1;
    logic       arb_enable = 1'b0;
    logic [3:0] req_i = '0;
    logic [5:0] cfg_burst_len = '0;
    logic       dma_ack_i = 1'b0;
    logic       dma_beat_i = 1'b0;
    logic       dma_req_o;
    logic [1:0] dma_ch_o;
    logic [5:0] dma_len_o;
    logic [3:0] gnt_o;
    logic       busy_o, done_o, abort_o;

    int checks = 0;
    int errors = 0;
    int exp_ch_q[$];
    int exp_len_q[$];
    int model_ptr = 0;
    int exp_done = 0;
    int done_seen = 0;
    bit stop_run = 1'b0;

    always #5 pclk = ~pclk;

    audio_dma_arbiter dut (
        .pclk          (pclk),
        .prst          (prst),
        .arb_enable    (arb_enable),
        .req_i         (req_i),
        .cfg_burst_len (cfg_burst_len),
        .dma_req_o     (dma_req_o),
        .dma_ch_o      (dma_ch_o),
        .dma_len_o     (dma_len_o),
        .dma_ack_i     (dma_ack_i),
        .dma_beat_i    (dma_beat_i),
        .gnt_o         (gnt_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .abort_o       (abort_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference rule: first requester at or after the pointer, wrapping around the ring of four.
    function automatic int pick(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    always @(negedge pclk) begin
        if (!prst) begin
            check("gnt_onehot0", 32'($onehot0(gnt_o)), 1);
            check("abort_quiet", 32'(abort_o), 0);
            if (!dma_req_o) begin
                check("cmd_fields_zero", 32'({dma_ch_o, dma_len_o}), 0);
            end
            if (dma_req_o && dma_ack_i) begin
                if (exp_ch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd actual=ch%0d expected=none", dma_ch_o);
                end else begin
                    int ch, len;
                    ch  = exp_ch_q.pop_front();
                    len = exp_len_q.pop_front();
                    check("cmd_ch", 32'(dma_ch_o), 32'(ch));
                    check("cmd_len", 32'(dma_len_o), 32'(len));
                    check("cmd_gnt", 32'(gnt_o), 32'(1 << ch));
                end
            end
            if (done_o) done_seen++;
        end
    end

    task automatic do_burst(input logic [3:0] r, input logic [5:0] l, input int ack_dly,
                            input bit drop_en, input bit rst_mid);
        int w, n, waited;
        if (stop_run) return;
        arb_enable    = 1'b1;
        req_i         = r;
        cfg_burst_len = l;
        w = pick(r, model_ptr);
        n = (l == 0) ? 1 : int'(l);
        exp_ch_q.push_back(w);
        exp_len_q.push_back(n);
        model_ptr = (w + 1) % 4;
        waited = 0;
        do begin
            @(posedge pclk); #1;
            waited++;
        end while (!dma_req_o && waited < 20);
        check("cmd_latency", 32'(dma_req_o && waited <= 2), 1);
        if (!dma_req_o) begin
            stop_run = 1'b1;
            return;
        end
        req_i         = 4'($urandom_range(0, 15));
        cfg_burst_len = 6'($urandom_range(0, 63));
        repeat (ack_dly) begin
            dma_beat_i = 1'($urandom_range(0, 1));
            @(posedge pclk); #1;
        end
        dma_ack_i  = 1'b1;
        dma_beat_i = 1'($urandom_range(0, 1));
        @(posedge pclk); #1;
        dma_ack_i  = 1'b0;
        dma_beat_i = 1'b0;
        if (drop_en) arb_enable = 1'b0;
        if (rst_mid) begin
            dma_beat_i = 1'b1;
            @(posedge pclk); #1;
            dma_beat_i = 1'b0;
            prst = 1'b1;
            @(posedge pclk); #1;
            check("rst_busy", 32'(busy_o), 0);
            check("rst_dma_req", 32'(dma_req_o), 0);
            check("rst_gnt", 32'(gnt_o), 0);
            prst       = 1'b0;
            req_i      = '0;
            model_ptr  = 0;
            return;
        end
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge pclk); #1;
            end
            dma_beat_i = 1'b1;
            @(posedge pclk); #1;
            dma_beat_i = 1'b0;
        end
        exp_done++;
        check("done_on_last_beat", 32'(done_o), 1);
        check("release_busy", 32'(busy_o), 1);
        check("release_gnt", 32'(gnt_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("reset_outputs", 32'({dma_req_o, dma_ch_o, dma_len_o, gnt_o, busy_o, done_o, abort_o}), 0);
        @(posedge pclk); #1;
        prst = 1'b0;

        do_burst(4'b0101, 6'd4, 2, 1'b0, 1'b0);
        do_burst(4'b0101, 6'd4, 2, 1'b0, 1'b0);
        repeat (8) do_burst(4'hF, 6'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        do_burst(4'b0010, 6'd0, 1, 1'b0, 1'b0);
        repeat (3) do_burst(4'b1000, 6'd2, 0, 1'b0, 1'b0);

        do_burst(4'hF, 6'd3, 1, 1'b1, 1'b0);
        req_i = 4'hF;
        repeat (6) begin
            @(posedge pclk); #1;
            check("disabled_no_cmd", 32'(dma_req_o), 0);
            check("disabled_idle", 32'(busy_o), 0);
        end

        do_burst(4'hF, 6'd8, 1, 1'b0, 1'b1);
        do_burst(4'hF, 6'd2, 0, 1'b0, 1'b0);

        repeat (60) do_burst(4'($urandom_range(1, 15)), 6'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), 1'b0, 1'b0);

        req_i = '0;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        check("done_count", 32'(done_seen), 32'(exp_done));
        check("cmd_queue_empty", 32'(exp_ch_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
